// File: rtl/simd_mac_pipe_if.sv
// rtl/simd_mac_pipe_if.sv - operand/result handshake bundle for simd_mac_pipe
// master drives beats and consumes results; slave is the MAC pipeline.
interface simd_mac_pipe_if #(
   parameter int LANES         = 4,
   parameter int BIT_WIDTH     = 32,
   parameter int OPCODE_BITS   = 4,
   parameter int FUNCTION_BITS = 4
);
   logic                       in_valid;
   logic                       in_ready;
   logic [OPCODE_BITS-1:0]     opcode;
   logic [FUNCTION_BITS-1:0]   fn;
   logic [LANES*BIT_WIDTH-1:0] data_in0;
   logic [LANES*BIT_WIDTH-1:0] data_in1;
   logic [LANES*BIT_WIDTH-1:0] data_acc;
   logic [7:0]                 dest_integer_bits;
   logic [7:0]                 src1_integer_bits;
   logic [7:0]                 src2_integer_bits;
   logic                       sat_clear;
   logic                       out_valid;
   logic                       out_ready;
   logic [LANES*BIT_WIDTH-1:0] data_out;
   logic [LANES-1:0]           sat_flag;

   modport master (
      output in_valid, opcode, fn, data_in0, data_in1, data_acc,
             dest_integer_bits, src1_integer_bits, src2_integer_bits,
             sat_clear, out_ready,
      input  in_ready, out_valid, data_out, sat_flag
   );

   modport slave (
      input  in_valid, opcode, fn, data_in0, data_in1, data_acc,
             dest_integer_bits, src1_integer_bits, src2_integer_bits,
             sat_clear, out_ready,
      output in_ready, out_valid, data_out, sat_flag
   );
endinterface

// File: rtl/simd_mac_pipe.sv
// rtl/simd_mac_pipe.sv - 3-stage multi-lane fixed-point MUL/MAC with per-lane accumulators
// S1: operands + decode + shift; S2: full product; S3: round/shift/saturate/accumulate.
module simd_mac_pipe #(
   parameter int LANES         = 4,
   parameter int BIT_WIDTH     = 32,
   parameter int OPCODE_BITS   = 4,
   parameter int FUNCTION_BITS = 4,
   parameter int ROUND         = 1
) (
   input logic            clk,
   input logic            reset,
   simd_mac_pipe_if.slave bus
);
   localparam int W   = BIT_WIDTH;
   localparam int SHW = $clog2(BIT_WIDTH + 1);

   localparam logic signed [2*W:0] MAX_WIDE = {{(W+2){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [2*W:0] MIN_WIDE = {{(W+2){1'b1}}, {(W-1){1'b0}}};
   localparam logic [W-1:0]        MAX_W    = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0]        MIN_W    = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [2:0] {
      OP_PASS, OP_MUL, OP_MAC, OP_MACC, OP_ACCLD, OP_LEAKY
   } op_e;

   typedef logic [LANES-1:0][W-1:0]   lanes_t;
   typedef logic [LANES-1:0][2*W-1:0] prods_t;

   // Round-half-up then arithmetic shift, widened by one bit so the bias cannot overflow.
   function automatic logic signed [2*W:0] scale(input logic [2*W-1:0] p,
                                                 input logic [SHW-1:0] sh);
      logic signed [2*W:0] x;
      x = $signed({p[2*W-1], p});
      if (ROUND != 0 && sh != '0)
         x = x + $signed((2*W+1)'(1) << (sh - SHW'(1)));
      return x >>> sh;
   endfunction

   // Returned as {saturated, value}.
   function automatic logic [W:0] sat_narrow(input logic signed [2*W:0] x);
      if (x > MAX_WIDE)      return {1'b1, MAX_W};
      else if (x < MIN_WIDE) return {1'b1, MIN_W};
      else                   return {1'b0, x[W-1:0]};
   endfunction

   function automatic logic [W:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] s;
      s = {a[W-1], a} + {b[W-1], b};
      if (s[W] != s[W-1]) return {1'b1, (s[W] ? MIN_W : MAX_W)};
      return {1'b0, s[W-1:0]};
   endfunction

   logic             en;
   op_e              in_op;
   logic signed [9:0] sh_raw;
   logic [SHW-1:0]   in_sh;

   logic             s1_valid_q, s1_valid_d;
   op_e              s1_op_q, s1_op_d;
   logic [SHW-1:0]   s1_sh_q, s1_sh_d;
   lanes_t           s1_in0_q, s1_in0_d;
   lanes_t           s1_in1_q, s1_in1_d;
   lanes_t           s1_acc_q, s1_acc_d;

   logic             s2_valid_q, s2_valid_d;
   op_e              s2_op_q, s2_op_d;
   logic [SHW-1:0]   s2_sh_q, s2_sh_d;
   prods_t           s2_prod_q, s2_prod_d;
   lanes_t           s2_in0_q, s2_in0_d;
   lanes_t           s2_acc_q, s2_acc_d;

   logic             out_valid_q, out_valid_d;
   lanes_t           data_out_q, data_out_d;
   lanes_t           acc_q, acc_d;
   logic [LANES-1:0] sat_q, sat_d;

   logic [LANES-1:0][W:0] mul_r;
   logic [LANES-1:0][W:0] add_r;
   lanes_t                lane_res;
   logic [LANES-1:0]      lane_evt;

   assign en            = ~out_valid_q | bus.out_ready;
   assign bus.in_ready  = en;
   assign bus.out_valid = out_valid_q;
   assign bus.data_out  = data_out_q;
   assign bus.sat_flag  = sat_q;

   always_comb begin
      in_op = OP_PASS;
      if (bus.opcode == OPCODE_BITS'(0)) begin
         case (bus.fn)
            FUNCTION_BITS'(2): in_op = OP_MUL;
            FUNCTION_BITS'(3): in_op = OP_MAC;
            FUNCTION_BITS'(4): in_op = OP_MACC;
            FUNCTION_BITS'(5): in_op = OP_ACCLD;
            default:           in_op = OP_PASS;
         endcase
      end else if (bus.opcode == OPCODE_BITS'(1) && bus.fn == FUNCTION_BITS'(1)) begin
         in_op = OP_LEAKY;
      end

      sh_raw = 10'(bus.src1_integer_bits) + 10'(bus.src2_integer_bits)
             + 10'(bus.dest_integer_bits) - 10'(W);
      if (sh_raw < 0)      in_sh = '0;
      else if (sh_raw > W) in_sh = SHW'(W);
      else                 in_sh = SHW'(sh_raw);
   end

   // Stage-3 lane math; MAC adds the beat's data_acc, MACC adds the held accumulator.
   always_comb begin
      mul_r    = '0;
      add_r    = '0;
      lane_res = '0;
      lane_evt = '0;
      for (int i = 0; i < LANES; i++) begin
         mul_r[i] = sat_narrow(scale(s2_prod_q[i], s2_sh_q));
         add_r[i] = sat_add((s2_op_q == OP_MAC) ? s2_acc_q[i] : acc_q[i], mul_r[i][W-1:0]);
         case (s2_op_q)
            OP_MUL: begin
               lane_res[i] = mul_r[i][W-1:0];
               lane_evt[i] = mul_r[i][W];
            end
            OP_MAC, OP_MACC: begin
               lane_res[i] = add_r[i][W-1:0];
               lane_evt[i] = mul_r[i][W] | add_r[i][W];
            end
            OP_ACCLD: lane_res[i] = s2_acc_q[i];
            OP_LEAKY: begin
               if (s2_in0_q[i][W-1]) begin
                  lane_res[i] = mul_r[i][W-1:0];
                  lane_evt[i] = mul_r[i][W];
               end else begin
                  lane_res[i] = s2_in0_q[i];
               end
            end
            default: lane_res[i] = s2_in0_q[i];
         endcase
      end
   end

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_op_d     = s1_op_q;
      s1_sh_d     = s1_sh_q;
      s1_in0_d    = s1_in0_q;
      s1_in1_d    = s1_in1_q;
      s1_acc_d    = s1_acc_q;
      s2_valid_d  = s2_valid_q;
      s2_op_d     = s2_op_q;
      s2_sh_d     = s2_sh_q;
      s2_prod_d   = s2_prod_q;
      s2_in0_d    = s2_in0_q;
      s2_acc_d    = s2_acc_q;
      out_valid_d = out_valid_q;
      data_out_d  = data_out_q;
      acc_d       = acc_q;
      sat_d       = sat_q;

      if (en) begin
         s1_valid_d  = bus.in_valid;
         s1_op_d     = in_op;
         s1_sh_d     = in_sh;
         s1_in0_d    = bus.data_in0;
         s1_in1_d    = bus.data_in1;
         s1_acc_d    = bus.data_acc;

         s2_valid_d  = s1_valid_q;
         s2_op_d     = s1_op_q;
         s2_sh_d     = s1_sh_q;
         s2_in0_d    = s1_in0_q;
         s2_acc_d    = s1_acc_q;
         for (int i = 0; i < LANES; i++) begin
            s2_prod_d[i] = $signed({{W{s1_in0_q[i][W-1]}}, s1_in0_q[i]})
                         * $signed({{W{s1_in1_q[i][W-1]}}, s1_in1_q[i]});
         end

         out_valid_d = s2_valid_q;
         if (s2_valid_q) begin
            data_out_d = lane_res;
            if (s2_op_q == OP_MACC || s2_op_q == OP_ACCLD)
               acc_d = lane_res;
         end
      end

      // Clear first so a same-cycle saturation event still leaves its flag set.
      if (bus.sat_clear)
         sat_d = '0;
      if (en && s2_valid_q)
         sat_d = sat_d | lane_evt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         s1_op_q     <= OP_PASS;
         s1_sh_q     <= '0;
         s1_in0_q    <= '0;
         s1_in1_q    <= '0;
         s1_acc_q    <= '0;
         s2_valid_q  <= 1'b0;
         s2_op_q     <= OP_PASS;
         s2_sh_q     <= '0;
         s2_prod_q   <= '0;
         s2_in0_q    <= '0;
         s2_acc_q    <= '0;
         out_valid_q <= 1'b0;
         data_out_q  <= '0;
         acc_q       <= '0;
         sat_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_op_q     <= s1_op_d;
         s1_sh_q     <= s1_sh_d;
         s1_in0_q    <= s1_in0_d;
         s1_in1_q    <= s1_in1_d;
         s1_acc_q    <= s1_acc_d;
         s2_valid_q  <= s2_valid_d;
         s2_op_q     <= s2_op_d;
         s2_sh_q     <= s2_sh_d;
         s2_prod_q   <= s2_prod_d;
         s2_in0_q    <= s2_in0_d;
         s2_acc_q    <= s2_acc_d;
         out_valid_q <= out_valid_d;
         data_out_q  <= data_out_d;
         acc_q       <= acc_d;
         sat_q       <= sat_d;
      end
   end
endmodule

// File: tb/tb_simd_mac_pipe.sv
// tb/tb_simd_mac_pipe.sv - directed bench for simd_mac_pipe (BIT_WIDTH=16, Q8.8)
// Two instances share stimulus; only the rounding one is scoreboarded beat by beat.
module tb_simd_mac_pipe;
   localparam int LANES = 4;
   localparam int W     = 16;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   simd_mac_pipe_if #(.LANES(LANES), .BIT_WIDTH(W), .OPCODE_BITS(4), .FUNCTION_BITS(4)) b1 ();
   simd_mac_pipe_if #(.LANES(LANES), .BIT_WIDTH(W), .OPCODE_BITS(4), .FUNCTION_BITS(4)) b0 ();

   simd_mac_pipe #(.LANES(LANES), .BIT_WIDTH(W), .OPCODE_BITS(4), .FUNCTION_BITS(4), .ROUND(1))
      u_dut (.clk(clk), .reset(reset), .bus(b1));
   simd_mac_pipe #(.LANES(LANES), .BIT_WIDTH(W), .OPCODE_BITS(4), .FUNCTION_BITS(4), .ROUND(0))
      u_dut_nr (.clk(clk), .reset(reset), .bus(b0));

   assign b0.in_valid          = b1.in_valid;
   assign b0.opcode            = b1.opcode;
   assign b0.fn                = b1.fn;
   assign b0.data_in0          = b1.data_in0;
   assign b0.data_in1          = b1.data_in1;
   assign b0.data_acc          = b1.data_acc;
   assign b0.dest_integer_bits = b1.dest_integer_bits;
   assign b0.src1_integer_bits = b1.src1_integer_bits;
   assign b0.src2_integer_bits = b1.src2_integer_bits;
   assign b0.sat_clear         = b1.sat_clear;
   assign b0.out_ready         = b1.out_ready;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_accepted = 0;
   logic [63:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] rep(input logic [15:0] v);
      return {4{v}};
   endfunction

   always @(negedge clk) begin
      if (!reset && b1.out_valid && b1.out_ready) begin
         if (exp_q.size() == 0)
            check_eq("extra_beat", 64'(exp_q.size()), 64'd1);
         else
            check_eq("beat_data", b1.data_out, exp_q.pop_front());
      end
   end

   // Presents a beat and returns one cycle after the edge that accepted it.
   task automatic send(input logic [3:0] opc, input logic [3:0] f, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] c, input logic [15:0] e);
      logic accepted;
      b1.opcode   = opc;
      b1.fn       = f;
      b1.data_in0 = rep(a);
      b1.data_in1 = rep(b);
      b1.data_acc = rep(c);
      b1.in_valid = 1'b1;
      accepted    = 1'b0;
      for (int t = 0; t < 40 && !accepted; t++) begin
         @(negedge clk);
         if (b1.in_ready) begin
            accepted = 1'b1;
            exp_q.push_back(rep(e));
            n_accepted++;
         end
         @(posedge clk); #1;
      end
      if (!accepted) check_eq("send_timeout", 64'(accepted), 64'd1);
   endtask

   task automatic idle();
      b1.in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 1;
      while (!b1.out_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic drain();
      for (int t = 0; t < 50 && exp_q.size() != 0; t++) begin
         @(posedge clk); #1;
      end
      check_eq("drain", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic clear_sat();
      b1.sat_clear = 1'b1;
      @(posedge clk); #1;
      b1.sat_clear = 1'b0;
   endtask

   task automatic set_q(input logic [7:0] s1, input logic [7:0] s2, input logic [7:0] d);
      b1.src1_integer_bits = s1;
      b1.src2_integer_bits = s2;
      b1.dest_integer_bits = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat;
      b1.in_valid  = 1'b0;
      b1.opcode    = '0;
      b1.fn        = '0;
      b1.data_in0  = '0;
      b1.data_in1  = '0;
      b1.data_acc  = '0;
      b1.sat_clear = 1'b0;
      b1.out_ready = 1'b1;
      set_q(8'd8, 8'd8, 8'd8);

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_out_valid", 64'(b1.out_valid), 64'd0);
      check_eq("rst_data_out", b1.data_out, 64'd0);
      check_eq("rst_sat_flag", 64'(b1.sat_flag), 64'd0);
      reset = 1'b0;
      #1;
      check_eq("rst_in_ready", 64'(b1.in_ready), 64'd1);

      // MUL Q8.8 and latency
      send(4'd0, 4'd2, 16'h0180, 16'h0200, 16'h0000, 16'h0300);
      idle();
      wait_out(lat);
      check_eq("mul_latency", 64'(lat), 64'd3);
      check_eq("mul_sat_flag", 64'(b1.sat_flag), 64'd0);
      drain();

      // positive saturation, stickiness, clear, negative saturation
      send(4'd0, 4'd2, 16'h7F00, 16'h0200, 16'h0000, 16'h7FFF);
      idle();
      drain();
      check_eq("sat_pos_flag", 64'(b1.sat_flag), 64'hF);
      send(4'd0, 4'd2, 16'h0180, 16'h0200, 16'h0000, 16'h0300);
      idle();
      drain();
      check_eq("sat_sticky", 64'(b1.sat_flag), 64'hF);
      clear_sat();
      check_eq("sat_cleared", 64'(b1.sat_flag), 64'h0);
      send(4'd0, 4'd2, 16'h8000, 16'h0200, 16'h0000, 16'h8000);
      idle();
      drain();
      check_eq("sat_neg_flag", 64'(b1.sat_flag), 64'hF);
      clear_sat();

      // clear asserted on the very edge the saturating beat enters S3
      send(4'd0, 4'd2, 16'h7F00, 16'h0200, 16'h0000, 16'h7FFF);
      idle();
      @(posedge clk); #1;
      b1.sat_clear = 1'b1;
      @(posedge clk); #1;
      b1.sat_clear = 1'b0;
      check_eq("sat_set_wins", 64'(b1.sat_flag), 64'hF);
      drain();
      clear_sat();

      // rounding on both instances
      send(4'd0, 4'd2, 16'h0001, 16'h0080, 16'h0000, 16'h0001);
      idle();
      wait_out(lat);
      check_eq("round_off_data", b0.data_out, rep(16'h0000));
      drain();

      // LEAKY, MAC, passthrough
      send(4'd1, 4'd1, 16'hFF00, 16'h0019, 16'h0000, 16'hFFE7);
      send(4'd1, 4'd1, 16'h0100, 16'h0019, 16'h0000, 16'h0100);
      send(4'd0, 4'd3, 16'h0180, 16'h0200, 16'h0010, 16'h0310);
      send(4'd2, 4'd2, 16'h1234, 16'h5555, 16'h0000, 16'h1234);
      send(4'd0, 4'd7, 16'hABCD, 16'h0200, 16'h0000, 16'hABCD);
      idle();
      drain();
      check_eq("leaky_no_sat", 64'(b1.sat_flag), 64'h0);

      // shift clamps: sh=32 -> 16, sh=-16 -> 0
      set_q(8'd16, 8'd16, 8'd16);
      send(4'd0, 4'd2, 16'h4000, 16'h4000, 16'h0000, 16'h1000);
      idle();
      drain();
      set_q(8'd0, 8'd0, 8'd0);
      send(4'd0, 4'd2, 16'h0003, 16'h0005, 16'h0000, 16'h000F);
      idle();
      drain();
      set_q(8'd8, 8'd8, 8'd8);

      // MACC chain: results on consecutive cycles
      send(4'd0, 4'd5, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      send(4'd0, 4'd4, 16'h0100, 16'h0100, 16'h0000, 16'h0100);
      send(4'd0, 4'd4, 16'h0100, 16'h0100, 16'h0000, 16'h0200);
      send(4'd0, 4'd4, 16'h0100, 16'h0100, 16'h0000, 16'h0300);
      idle();
      for (int k = 0; k < 3; k++) begin
         check_eq("chain_valid", 64'(b1.out_valid), 64'd1);
         @(posedge clk); #1;
      end
      check_eq("chain_end", 64'(b1.out_valid), 64'd0);
      send(4'd0, 4'd4, 16'h7F00, 16'h0100, 16'h0000, 16'h7FFF);
      idle();
      drain();
      check_eq("macc_sat_flag", 64'(b1.sat_flag), 64'hF);
      clear_sat();

      // backpressure: 5 MACC beats, out_ready low for 6 cycles
      send(4'd0, 4'd5, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      idle();
      drain();
      b1.out_ready = 1'b0;
      n_accepted   = 0;
      fork
         begin
            for (int k = 0; k < 5; k++)
               send(4'd0, 4'd4, 16'h0100, 16'h0100, 16'h0000, 16'(256 * (k + 1)));
            idle();
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            check_eq("bp_in_ready_low", 64'(b1.in_ready), 64'd0);
            check_eq("bp_in_flight", 64'(n_accepted), 64'd3);
            repeat (2) @(posedge clk);
            #1;
            check_eq("bp_data_hold", b1.data_out, rep(16'h0100));
            @(posedge clk); #1;
            b1.out_ready = 1'b1;
         end
      join
      drain();
      send(4'd0, 4'd4, 16'h0100, 16'h0000, 16'h0000, 16'h0500);
      idle();
      drain();

      // reset mid-flight discards beats and clears accumulators
      send(4'd0, 4'd5, 16'h0000, 16'h0000, 16'h1000, 16'h1000);
      send(4'd0, 4'd4, 16'h0100, 16'h0100, 16'h0000, 16'h1100);
      idle();
      reset = 1'b1;
      exp_q.delete();
      #1;
      check_eq("midrst_out_valid", 64'(b1.out_valid), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      send(4'd0, 4'd4, 16'h0100, 16'h0100, 16'h0000, 16'h0100);
      idle();
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/simd_mac_pipe.md
# simd_mac_pipe

Pipelined, multi-lane fixed-point multiply / multiply-accumulate unit for the SIMD datapath. Each beat carries `LANES` signed operands per source, and every lane is processed identically under one opcode/fn and one set of Q-format descriptors. The block adds a valid/ready handshake, a 3-stage pipeline, optional round-to-nearest, per-lane persistent accumulators and sticky saturation flags. It sits between the operand-read stage and the writeback buffer of the vector ALU.

## Interface
- `LANES`, 4, number of parallel lanes
- `BIT_WIDTH`, 32, signed width of each lane element
- `OPCODE_BITS`, 4, opcode width
- `FUNCTION_BITS`, 4, function-code width
- `ROUND`, 1, 1 = round-half-up before truncation; 0 = truncate
- `clk`  in  1  single clock; all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  block accepts beat this cycle
- `opcode`  in  OPCODE_BITS  operation class
- `fn`  in  FUNCTION_BITS  function within class
- `data_in0`, `data_in1`, `data_acc`  in  LANES*BIT_WIDTH  packed signed lanes; lane i at `[i*BIT_WIDTH +: BIT_WIDTH]`
- `dest_integer_bits`, `src1_integer_bits`, `src2_integer_bits`  in  8 each  Q-format integer bit counts for this beat
- `sat_clear`  in  1  synchronous clear of all sticky saturation flags
- `out_valid`  out  1  output beat valid
- `out_ready`  in  1  downstream accepts output
- `data_out`  out  LANES*BIT_WIDTH  packed signed results
- `sat_flag`  out  LANES  sticky per-lane saturation indicator

## Operation
- Ops (all lanes): opcode 0 / fn 2 MUL: `sat(mul)`. Opcode 0 / fn 3 MAC: `sat(mul + data_acc)`. Opcode 0 / fn 4 MACC: `acc[i] <= sat(acc[i] + mul)`; output is the new `acc[i]`. Opcode 0 / fn 5 ACCLD: `acc[i] <= data_acc`; output is `data_acc`. Opcode 1 / fn 1 LEAKY: `data_in0 >= 0 ? data_in0 : mul`. Any other opcode/fn: pass `data_in0`.
- Shift: `sh = src1 + src2 + dest - BIT_WIDTH`, evaluated signed at 10 bits and clamped to [0, BIT_WIDTH].
- `mul` step 1: product P = `in0*in1`, full 2*BIT_WIDTH signed.
- `mul` step 2: if `ROUND` and `sh > 0`, P += 2^(sh-1), computed in 2*BIT_WIDTH+1 bits.
- `mul` step 3: arithmetic right shift by `sh`, then saturate to BIT_WIDTH bits. The limits are +2^(W-1)-1 and -2^(W-1).
- Accumulator adds use BIT_WIDTH+1 bits and saturate to the same limits.
- Saturation event: the mul saturation or the add saturation fires in a lane whose op uses it (MUL, MAC, MACC, or LEAKY with a negative input). That lane's `sat_flag` is then set when the beat enters stage 3.
- Flag clearing: `sat_flag` clears only on `reset` or `sat_clear`. If a set and a clear land in the same cycle, set wins.
- Accumulator update timing: `acc[i]` updates only at the cycle its MACC/ACCLD beat enters stage 3, exactly once per beat. Back-to-back MACC beats chain with no bubble.

## Timing
- Pipeline: S1 registers operands and decode. S2 registers the full product and `sh`. S3 does round, shift, saturate and accumulate, and registers `data_out`.
- Latency: 3 cycles from accepted beat (`in_valid & in_ready`) to `out_valid`. Throughput is 1 beat/cycle.
- Advance enable: `en = ~out_valid | out_ready`, and `in_ready = en`. The whole pipeline freezes when `en = 0`. Valid bits propagate with `en`, and bubbles occupy slots.
- While stalled: `data_out`, `out_valid` and `acc` hold. No accumulator update happens.
- Ordering: in order, no drops, no duplicates.
- Reset values: `out_valid = 0`, `data_out = 0`, `sat_flag = 0`, all `acc = 0`, all stage valids 0. `in_ready` = 1 once reset deasserts.
- Reset mid-operation discards every in-flight beat and clears the accumulators.
- `sat_clear` acts regardless of `en`.

## Test plan
- MUL, BIT_WIDTH=16, Q8.8 (src1=src2=dest=8, sh=8): lane0 `0x0180 × 0x0200` -> `0x0300`; `out_valid` 3 cycles after accept; `sat_flag = 0`.
- Saturation: `0x7F00 × 0x0200` -> `0x7FFF`, `sat_flag[0] = 1`. It stays 1 across later clean beats until a `sat_clear` pulse, then reads 0. `0x8000 × 0x0200` -> `0x8000`.
- Rounding: `0x0001 × 0x0080`, sh=8 -> `0x0001` with ROUND=1 and `0x0000` with ROUND=0.
- LEAKY: in0 `0xFF00`, in1 `0x0019` -> `0xFFE7`. in0 `0x0100` -> `0x0100` unchanged.
- MACC chain: ACCLD `0x0000`, then 3 back-to-back MACC `0x0100 × 0x0100` -> outputs `0x0000`, `0x0100`, `0x0200`, `0x0300` on consecutive cycles. A following `0x7F00` add saturates to `0x7FFF`.
- Backpressure: send 5 MACC beats with `out_ready` low for 6 cycles. `in_ready` drops after 3 beats are in flight. On release, all 5 results appear in order, and the accumulator equals exactly 5 increments.
